uart_tx: RTL and testbench

UART transmit engine, directly downstream of the UART register block. It accepts byte-write pulses from the TXDATA register path into a small byte FIFO. It serialises each byte onto tx_o as a start bit, 8 data bits (LSB first), an optional parity bit and 1 or 2 stop bits, timed by the programmed divider. It returns TXStatus_t and a masked interrupt to the register block.

---
 rtl/uart_tx_pkg.sv | 38 +++
 rtl/uart_tx_fifo.sv | 59 +++++
 rtl/uart_tx.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path.
//   TXState_t  : transmit FSM state encoding
//   TXStatus_t : {overflow, fifo_full, fifo_empty, busy}, busy in bit 0
//   Config_t   : {mode[1:0], master, parity_en, parity_odd, stop2}
//   bit_reload : counter reload value for one bit period, divider 0/1 -> 1 clk
package uart_tx_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } TXState_t;

    typedef struct packed {
        logic overflow;
        logic fifo_full;
        logic fifo_empty;
        logic busy;
    } TXStatus_t;

    typedef struct packed {
        logic [1:0] mode;
        logic       master;
        logic       parity_en;
        logic       parity_odd;
        logic       stop2;
    } Config_t;

    localparam logic [2:0] LAST_DATA_BIT = 3'd7;

    // The bit counter counts down to zero, so a bit lasts reload+1 cycles.
    function automatic logic [31:0] bit_reload(input logic [31:0] div);
        return (div <= 32'd1) ? 32'd0 : (div - 32'd1);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Generic synchronous FIFO, shared by the UART transmit and receive paths.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_flush    : empties the FIFO; wins over push and pop
//   i_push     : write i_data (ignored while full)
//   i_pop      : advance read pointer (ignored while empty)
//   o_data     : head entry, valid while !o_empty
//   o_full     : registered-pointer full flag
//   o_empty    : registered-pointer empty flag
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Extra MSB is the wrap bit: equal LSBs with differing MSBs means full.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // Full is judged on the registered pointers, so a same-cycle pop does
    // not make room for a push.
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmit engine. Bytes written from the TXDATA register path are
// queued in a FIFO and sent as start, 8 data bits LSB first, optional
// parity and 1 or 2 stop bits, each bit lasting max(divider,1) clocks.
//   clk, rst_n     : clock, asynchronous active-low reset
//   tx_enable_i    : transmitter enable; low aborts, flushes, clears overflow
//   divider_i      : clocks per bit, latched at frame start
//   uart_config_i  : parity_en/parity_odd/stop2 latched at frame start
//   tx_d_i         : byte to queue
//   tx_d_valid_i   : single-cycle write pulse, no backpressure
//   txirqmask_i    : interrupt mask, bits [3:0] used
//   tx_o           : registered serial line, idle high
//   tx_status_o    : {overflow, fifo_full, fifo_empty, busy}
//   tx_irq_o       : registered |(status & mask)
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_enable_i,
    input  logic [31:0] divider_i,
    input  Config_t     uart_config_i,
    input  logic [7:0]  tx_d_i,
    input  logic        tx_d_valid_i,
    input  logic [31:0] txirqmask_i,
    output logic        tx_o,
    output TXStatus_t   tx_status_o,
    output logic        tx_irq_o
);
    TXState_t    r_state, w_state_n;
    logic [7:0]  r_shift, w_shift_n;
    logic [2:0]  r_bit_idx, w_bit_idx_n;
    logic [31:0] r_cnt, w_cnt_n;
    logic [31:0] r_reload, w_reload_n;
    logic        r_par_en, w_par_en_n;
    logic        r_stop2, w_stop2_n;
    logic        r_par_bit, w_par_bit_n;
    logic        r_tx, w_tx_n;
    logic        r_overflow;
    logic        r_irq;

    logic        w_pop;
    logic        w_load;
    logic        w_bit_end;
    logic [7:0]  w_fifo_data;
    logic        w_full;
    logic        w_empty;
    TXStatus_t   w_status;
    logic        w_unused;

    // Mode decoding belongs to the register block; only enable gates us.
    assign w_unused = ^{uart_config_i.mode, uart_config_i.master, txirqmask_i[31:4]};

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (!tx_enable_i),
        .i_push  (tx_d_valid_i && tx_enable_i),
        .i_data  (tx_d_i),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_bit_end = (r_cnt == 32'd0);

    // tx_o is registered, so the line value for the next cycle is computed
    // here together with the next state.
    always_comb begin
        w_state_n   = r_state;
        w_shift_n   = r_shift;
        w_bit_idx_n = r_bit_idx;
        w_cnt_n     = r_cnt;
        w_reload_n  = r_reload;
        w_par_en_n  = r_par_en;
        w_stop2_n   = r_stop2;
        w_par_bit_n = r_par_bit;
        w_tx_n      = r_tx;
        w_pop       = 1'b0;
        w_load      = 1'b0;

        if (!tx_enable_i) begin
            w_state_n = TX_IDLE;
            w_tx_n    = 1'b1;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    w_tx_n = 1'b1;
                    if (!w_empty) w_load = 1'b1;
                end
                TX_START: begin
                    if (w_bit_end) begin
                        w_state_n   = TX_DATA;
                        w_bit_idx_n = 3'd0;
                        w_cnt_n     = r_reload;
                        w_tx_n      = r_shift[0];
                    end else begin
                        w_cnt_n = r_cnt - 32'd1;
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        w_cnt_n = r_reload;
                        if (r_bit_idx == LAST_DATA_BIT) begin
                            w_bit_idx_n = 3'd0;
                            if (r_par_en) begin
                                w_state_n = TX_PARITY;
                                w_tx_n    = r_par_bit;
                            end else begin
                                w_state_n = TX_STOP;
                                w_tx_n    = 1'b1;
                            end
                        end else begin
                            // r_shift[1] is the bit that lands in [0] after the shift.
                            w_shift_n   = {1'b0, r_shift[7:1]};
                            w_tx_n      = r_shift[1];
                            w_bit_idx_n = r_bit_idx + 3'd1;
                        end
                    end else begin
                        w_cnt_n = r_cnt - 32'd1;
                    end
                end
                TX_PARITY: begin
                    if (w_bit_end) begin
                        w_state_n   = TX_STOP;
                        w_bit_idx_n = 3'd0;
                        w_cnt_n     = r_reload;
                        w_tx_n      = 1'b1;
                    end else begin
                        w_cnt_n = r_cnt - 32'd1;
                    end
                end
                TX_STOP: begin
                    if (w_bit_end) begin
                        // bit_idx counts completed stop bits.
                        if (r_stop2 && (r_bit_idx == 3'd0)) begin
                            w_bit_idx_n = 3'd1;
                            w_cnt_n     = r_reload;
                        end else if (!w_empty) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_n = TX_IDLE;
                            w_tx_n    = 1'b1;
                        end
                    end else begin
                        w_cnt_n = r_cnt - 32'd1;
                    end
                end
                default: begin
                    w_state_n = TX_IDLE;
                    w_tx_n    = 1'b1;
                end
            endcase
        end

        // Frame start: shared by idle and back-to-back stop exit so there
        // is no idle gap between queued frames.
        if (w_load) begin
            w_pop       = 1'b1;
            w_state_n   = TX_START;
            w_shift_n   = w_fifo_data;
            w_reload_n  = bit_reload(divider_i);
            w_cnt_n     = bit_reload(divider_i);
            w_par_en_n  = uart_config_i.parity_en;
            w_stop2_n   = uart_config_i.stop2;
            w_par_bit_n = (^w_fifo_data) ^ uart_config_i.parity_odd;
            w_bit_idx_n = 3'd0;
            w_tx_n      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= TX_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_cnt     <= '0;
            r_reload  <= '0;
            r_par_en  <= 1'b0;
            r_stop2   <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_n;
            r_shift   <= w_shift_n;
            r_bit_idx <= w_bit_idx_n;
            r_cnt     <= w_cnt_n;
            r_reload  <= w_reload_n;
            r_par_en  <= w_par_en_n;
            r_stop2   <= w_stop2_n;
            r_par_bit <= w_par_bit_n;
            r_tx      <= w_tx_n;
        end
    end

    // Overflow is sticky while enabled; a write into a full FIFO sets it
    // even if a pop happens in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (!tx_enable_i) begin
            r_overflow <= 1'b0;
        end else if (tx_d_valid_i && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign w_status.overflow   = r_overflow;
    assign w_status.fifo_full  = w_full;
    assign w_status.fifo_empty = w_empty;
    assign w_status.busy       = (r_state != TX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(w_status & txirqmask_i[3:0]);
        end
    end

    assign tx_o        = r_tx;
    assign tx_status_o = w_status;
    assign tx_irq_o    = r_irq;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of directed frames, randomized
// frames against a bit-list reference model, and hand-written sequences
// for overflow, mid-frame disable and asynchronous reset.
module tb_uart_tx;
    import uart_tx_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        tx_enable;
    logic [31:0] divider;
    Config_t     cfg;
    logic [7:0]  tx_d;
    logic        tx_d_valid;
    logic [31:0] irq_mask;
    logic        tx_line;
    TXStatus_t   status;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [0:0] exp_q[$];
    logic [0:0] got_q[$];

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         pe;
        bit         po;
        bit         s2;
        int         exp_len;
        int         exp_par;
    } vec_t;

    vec_t vecs[6];

    uart_tx #(.FIFO_DEPTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_enable_i   (tx_enable),
        .divider_i     (divider),
        .uart_config_i (cfg),
        .tx_d_i        (tx_d),
        .tx_d_valid_i  (tx_d_valid),
        .txirqmask_i   (irq_mask),
        .tx_o          (tx_line),
        .tx_status_o   (status),
        .tx_irq_o      (irq)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference model: one entry per clock of line level for a whole frame.
    task automatic model_frame(input logic [7:0] b, input int div, input bit pe,
                               input bit po, input bit s2);
        int bits[$];
        int per;
        per = (div < 1) ? 1 : div;
        bits.push_back(0);
        for (int i = 0; i < 8; i++) bits.push_back((b >> i) & 1);
        if (pe) bits.push_back(($countones(b) % 2) ^ int'(po));
        bits.push_back(1);
        if (s2) bits.push_back(1);
        foreach (bits[k])
            for (int c = 0; c < per; c++) exp_q.push_back(bits[k][0]);
    endtask

    task automatic compare_stream(input string name);
        int n;
        check({name, "_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_bit%0d", name, i), {31'd0, got_q[i]}, {31'd0, exp_q[i]});
    endtask

    // Records the line from the current cycle while busy is high.
    task automatic capture_while_busy();
        int n;
        n = 0;
        while (status.busy && n < 5000) begin
            got_q.push_back(tx_line);
            tick();
            n++;
        end
    endtask

    // Driver: one byte into an idle block, then check the complete frame.
    task automatic send_frame(input string name, input logic [7:0] b, input int div,
                              input bit pe, input bit po, input bit s2,
                              input int exp_len, input int exp_par);
        int per;
        per = (div < 1) ? 1 : div;
        divider = div;
        cfg.parity_en = pe;
        cfg.parity_odd = po;
        cfg.stop2 = s2;
        tx_d = b;
        tx_d_valid = 1'b1;
        tick();
        tx_d_valid = 1'b0;
        check({name, "_n1_busy_tx"}, {30'd0, status.busy, tx_line}, 32'd1);
        tick();
        exp_q.delete();
        got_q.delete();
        model_frame(b, div, pe, po, s2);
        capture_while_busy();
        check({name, "_busy_cycles"}, got_q.size(), exp_len);
        compare_stream(name);
        if (pe && got_q.size() > 9 * per)
            check({name, "_parity"}, {31'd0, got_q[9 * per]}, exp_par);
        check({name, "_idle_after"}, {28'd0, status}, 32'h2);
        check({name, "_line_after"}, {31'd0, tx_line}, 32'd1);
    endtask

    initial begin : main
        logic [7:0] ov_bytes[10];
        logic [7:0] rb;
        int rdiv;
        bit rpe, rpo, rs2;

        vecs[0] = '{8'hA5, 4, 0, 0, 0, 40, 0};
        vecs[1] = '{8'h07, 3, 1, 0, 1, 36, 1};
        vecs[2] = '{8'hFF, 0, 0, 0, 0, 10, 0};
        vecs[3] = '{8'hFF, 1, 0, 0, 0, 10, 0};
        vecs[4] = '{8'h3C, 2, 1, 1, 0, 22, 1};
        vecs[5] = '{8'h00, 5, 1, 1, 1, 60, 1};

        rst_n = 1'b0;
        tx_enable = 1'b0;
        divider = 32'd4;
        cfg = '0;
        tx_d = 8'h00;
        tx_d_valid = 1'b0;
        irq_mask = 32'd0;
        repeat (3) tick();
        check("reset_tx", {31'd0, tx_line}, 32'd1);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_status", {28'd0, status}, 32'h2);
        rst_n = 1'b1;
        tick();

        // Writes while disabled are ignored.
        tx_d = 8'h99;
        tx_d_valid = 1'b1;
        tick();
        tx_d_valid = 1'b0;
        tx_enable = 1'b1;
        repeat (3) tick();
        check("disabled_write_ignored", {28'd0, status}, 32'h2);
        check("disabled_write_line", {31'd0, tx_line}, 32'd1);

        foreach (vecs[v])
            send_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].div, vecs[v].pe,
                       vecs[v].po, vecs[v].s2, vecs[v].exp_len, vecs[v].exp_par);

        for (int r = 0; r < 16; r++) begin
            rb = 8'($urandom_range(0, 255));
            rdiv = $urandom_range(0, 4);
            rpe = 1'($urandom_range(0, 1));
            rpo = 1'($urandom_range(0, 1));
            rs2 = 1'($urandom_range(0, 1));
            send_frame($sformatf("rnd%0d", r), rb, rdiv, rpe, rpo, rs2,
                       (10 + int'(rpe) + int'(rs2)) * ((rdiv < 1) ? 1 : rdiv),
                       ($countones(rb) % 2) ^ int'(rpo));
        end

        // Ten back-to-back writes: first pops at once, 8 fill, tenth dropped.
        irq_mask = 32'h8;
        divider = 32'd1;
        cfg.parity_en = 1'b0;
        cfg.parity_odd = 1'b0;
        cfg.stop2 = 1'b0;
        tick();
        check("ov_irq_before", {31'd0, irq}, 32'd0);
        exp_q.delete();
        got_q.delete();
        foreach (ov_bytes[i]) ov_bytes[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 9; i++) model_frame(ov_bytes[i], 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tx_d = ov_bytes[i];
            tx_d_valid = 1'b1;
            tick();
            if (i >= 1) got_q.push_back(tx_line);
            if (i == 9) check("ov_full", {31'd0, status.fifo_full}, 32'd1);
        end
        tx_d_valid = 1'b0;
        check("ov_overflow_set", {31'd0, status.overflow}, 32'd1);
        tick();
        check("ov_irq", {31'd0, irq}, 32'd1);
        capture_while_busy();
        compare_stream("ov_stream");
        check("ov_sticky_status", {28'd0, status}, 32'hA);
        irq_mask = 32'd0;

        // Disable during data bit 3 with bytes still queued.
        divider = 32'd4;
        for (int i = 0; i < 3; i++) begin
            tx_d = 8'h12 + 8'(i * 8'h22);
            tx_d_valid = 1'b1;
            tick();
        end
        tx_d_valid = 1'b0;
        repeat (16) tick();
        check("dis_pre_line", {30'd0, status.busy, tx_line}, 32'h2);
        tx_enable = 1'b0;
        tick();
        check("dis_line", {31'd0, tx_line}, 32'd1);
        check("dis_status", {28'd0, status}, 32'h2);
        tx_enable = 1'b1;
        repeat (3) tick();
        check("dis_flushed", {28'd0, status}, 32'h2);
        send_frame("reenable", 8'h55, 4, 0, 0, 0, 40, 0);

        // Asynchronous reset during the start bit.
        divider = 32'd8;
        tx_d = 8'hA5;
        tx_d_valid = 1'b1;
        tick();
        tx_d_valid = 1'b0;
        tick();
        tick();
        check("areset_pre_line", {31'd0, tx_line}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_line_now", {31'd0, tx_line}, 32'd1);
        check("areset_status_now", {28'd0, status}, 32'h2);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("areset_status_after", {28'd0, status}, 32'h2);
        check("areset_line_after", {31'd0, tx_line}, 32'd1);
        check("areset_irq_after", {31'd0, irq}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
